// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the apb_regfile register block.
// Optional byte strobes are enabled with the APB_REGFILE_PSTRB_EN macro.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_state_e;

    localparam int MAX_WAIT_CYCLES = 15;

    // The counter is loaded with the wait-state count, so it must hold that value; never narrower than 1 bit.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 2) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB transfer sequencer: setup capture, wait-state counting, a one-cycle
// registered pready and the commit strobe for the register file.
module apb_wait_ctrl
    import apb_regfile_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    output logic capture,
    output logic load_rsp,
    output logic commit,
    output logic pready
);

    localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;
    localparam int CNT_W    = cnt_width(WAIT_EFF);

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pready_q, pready_d;

    // NOTE: every signal written in an always_comb gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    cnt_d   = CNT_W'(WAIT_EFF);
                    state_d = (WAIT_EFF == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // A dropped psel here is an abort: leave without writing.
                commit  = psel;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pready_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
        end
    end

    assign load_rsp = pready_d;
    assign pready   = pready_q;

endmodule

// File: rtl/apb_regfile.sv
// Parametrised APB register file with wait states, read-only mask and a hardware write port.
// Define APB_REGFILE_PSTRB_EN to add the pstrb port and byte-granular writes.
module apb_regfile
    import apb_regfile_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 8,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_CYCLES = 2,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0]        pstrb,
`endif
    output logic                       pready,
    output logic                       pslverr,
    output logic [DATA_W-1:0]          prdata,
    input  logic                       hw_we,
    input  logic [ADDR_W-1:0]          hw_idx,
    input  logic [DATA_W-1:0]          hw_wdata,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int NBYTES = DATA_W / 8;

    logic capture, load_rsp, commit;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef APB_REGFILE_PSTRB_EN
    logic [NBYTES-1:0] strb_q, strb_d;
`endif

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_val;
    logic              rsp_err;
    logic              apb_wr;

    apb_wait_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_ctrl (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .capture (capture),
        .load_rsp(load_rsp),
        .commit  (commit),
        .pready  (pready)
    );

    // Unmapped indices always error; mapped ones error only on a write to a read-only register.
    function automatic logic is_err(input logic [ADDR_W-1:0] idx, input logic wr);
        logic err;
        err = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) err = wr && RO_MASK[i];
        end
        return err;
    endfunction

    always_comb begin
        addr_d  = capture ? paddr  : addr_q;
        we_d    = capture ? pwrite : we_q;
        wdata_d = capture ? pwdata : wdata_q;
`ifdef APB_REGFILE_PSTRB_EN
        strb_d  = capture ? pstrb  : strb_q;
        for (int k = 0; k < NBYTES; k++) wmask[k*8 +: 8] = {8{strb_q[k]}};
`else
        wmask   = '1;
`endif
    end

    // With zero wait states the response loads on the setup edge, so decode from the
    // values being captured rather than the stale ones.
    always_comb begin
        rsp_err = is_err(addr_d, we_d);
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_d == ADDR_W'(i)) rd_val = regs_q[i];
        end
        pslverr_d = load_rsp && rsp_err;
        prdata_d  = (load_rsp && !rsp_err && !we_d) ? rd_val : '0;
    end

    // The APB commit takes priority over a hardware write to the same register.
    always_comb begin
        apb_wr = commit && we_q && !is_err(addr_q, we_q);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (apb_wr && addr_q == ADDR_W'(i)) begin
                regs_d[i] = (regs_q[i] & ~wmask) | (wdata_q & wmask);
            end else if (hw_we && hw_idx == ADDR_W'(i)) begin
                regs_d[i] = hw_wdata;
            end
        end
    end

    // NOTE: the register array is reset because software and the core may rely on a known all-zero state.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
`ifdef APB_REGFILE_PSTRB_EN
            strb_q    <= '0;
`endif
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
`ifdef APB_REGFILE_PSTRB_EN
            strb_q    <= strb_d;
`endif
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_regfile.sv
// Self-checking bench for apb_regfile: a two-wait-state instance with a read-only
// register driven from a vector table, and a zero-wait instance for back-to-back transfers.
`timescale 1ns/1ps
module tb_apb_regfile;

    localparam int              DW = 32;
    localparam int              NR = 16;
    localparam int              WC = 2;
    localparam logic [NR-1:0]   RO = 16'h0004;

    logic           pclk = 1'b0;
    logic           presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic           psel, penable, pwrite;
    logic [7:0]     paddr;
    logic [31:0]    pwdata;
`ifdef APB_REGFILE_PSTRB_EN
    logic [3:0]     pstrb;
`endif
    logic           pready, pslverr;
    logic [31:0]    prdata;
    logic           hw_we;
    logic [7:0]     hw_idx;
    logic [31:0]    hw_wdata;
    logic [NR*DW-1:0] reg_q;

    logic           psel_z, penable_z, pwrite_z;
    logic [1:0]     paddr_z;
    logic [31:0]    pwdata_z;
`ifdef APB_REGFILE_PSTRB_EN
    logic [3:0]     pstrb_z;
`endif
    logic           pready_z, pslverr_z;
    logic [31:0]    prdata_z;
    logic           hw_we_z;
    logic [1:0]     hw_idx_z;
    logic [31:0]    hw_wdata_z;
    logic [4*DW-1:0] reg_q_z;

    apb_regfile #(
        .DATA_W(DW), .ADDR_W(8), .NUM_REGS(NR), .WAIT_CYCLES(WC), .RO_MASK(RO)
    ) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata), .reg_q(reg_q)
    );

    apb_regfile #(
        .DATA_W(DW), .ADDR_W(2), .NUM_REGS(4), .WAIT_CYCLES(0), .RO_MASK(4'h0)
    ) dut_z (
        .pclk(pclk), .presetn(presetn), .psel(psel_z), .penable(penable_z), .pwrite(pwrite_z),
        .paddr(paddr_z), .pwdata(pwdata_z),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb(pstrb_z),
`endif
        .pready(pready_z), .pslverr(pslverr_z), .prdata(prdata_z),
        .hw_we(hw_we_z), .hw_idx(hw_idx_z), .hw_wdata(hw_wdata_z), .reg_q(reg_q_z)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] mdl[NR];
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_reg%0d", name, i), reg_q[i*DW +: DW], mdl[i]);
        end
    endtask

    // One full transfer on the main instance; optionally fires the hardware port on the commit edge.
    task automatic apb_xfer(input string name, input logic wr, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] strb,
                            input logic e_err, input logic [31:0] e_rd,
                            input logic hw_en, input logic [7:0] hw_i, input logic [31:0] hw_d);
        exp_t        e;
        int          lat;
        bit          seen;
        logic [31:0] m, apb_new;
        exp_q.push_back('{err: e_err, rd: e_rd, lat: WC + 1});
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb = strb;
`endif
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
            else begin
                @(posedge pclk); #1;
                lat++;
            end
        end
        e = exp_q.pop_front();
        if (!seen) begin
            check({name, "_pready_timeout"}, {31'b0, pready}, 32'd1);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(e.lat));
            check({name, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
            if (!wr || e.err) check({name, "_prdata"}, prdata, e.rd);
            if (hw_en) begin
                hw_we = 1'b1; hw_idx = hw_i; hw_wdata = hw_d;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; hw_we = 1'b0;
        if (seen) begin
            for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{strb[k]}};
            apb_new = (a < NR) ? ((mdl[a[3:0]] & ~m) | (d & m)) : 32'h0;
            if (hw_en && hw_i < NR) mdl[hw_i[3:0]] = hw_d;
            if (wr && !e_err && a < NR) mdl[a[3:0]] = apb_new;
        end
    endtask

    task automatic hw_write(input logic [7:0] i, input logic [31:0] d);
        @(posedge pclk); #1;
        hw_we = 1'b1; hw_idx = i; hw_wdata = d;
        @(posedge pclk); #1;
        hw_we = 1'b0;
        if (i < NR) mdl[i[3:0]] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_rdy;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        hw_we = 0; hw_idx = '0; hw_wdata = '0;
        psel_z = 0; penable_z = 0; pwrite_z = 0; paddr_z = '0; pwdata_z = '0;
        hw_we_z = 0; hw_idx_z = '0; hw_wdata_z = '0;
`ifdef APB_REGFILE_PSTRB_EN
        pstrb = 4'hF; pstrb_z = 4'hF;
`endif
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;

        vecs[0] = '{1'b1, 8'd3,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 8'd3,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 8'd16,  32'h0,        1'b1, 32'h0};
        vecs[3] = '{1'b1, 8'd2,   32'h00000055, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 8'd2,   32'h0,        1'b0, 32'h0};
        vecs[5] = '{1'b1, 8'd15,  32'h12345678, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 8'd15,  32'h0,        1'b0, 32'h12345678};
        vecs[7] = '{1'b0, 8'd255, 32'h0,        1'b1, 32'h0};
        vecs[8] = '{1'b1, 8'd0,   32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 8'd0,   32'h0,        1'b0, 32'hA5A5A5A5};

        repeat (3) @(negedge pclk);
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        check("reset_prdata", prdata, 32'h0);
        check_regs("reset");
        for (int i = 0; i < 4; i++) check($sformatf("reset_z_reg%0d", i), reg_q_z[i*DW +: DW], 32'h0);
        presetn = 1'b1;

        for (int v = 0; v < 10; v++) begin
            apb_xfer($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata, 4'hF,
                     vecs[v].e_err, vecs[v].e_rd, 1'b0, 8'd0, 32'h0);
        end
        check_regs("table");
        check("ro_reg2_kept", reg_q[2*DW +: DW], 32'h0);

        apb_xfer("coll_same", 1'b1, 8'd5, 32'h0000ABCD, 4'hF, 1'b0, 32'h0, 1'b1, 8'd5, 32'h00001234);
        check("coll_same_reg5", reg_q[5*DW +: DW], 32'h0000ABCD);
        apb_xfer("coll_diff", 1'b1, 8'd6, 32'h0000ABCD, 4'hF, 1'b0, 32'h0, 1'b1, 8'd5, 32'h00001234);
        check("coll_diff_reg5", reg_q[5*DW +: DW], 32'h00001234);
        check("coll_diff_reg6", reg_q[6*DW +: DW], 32'h0000ABCD);

        hw_write(8'd2, 32'h00000077);
        hw_write(8'd20, 32'h00000BAD);
        check_regs("hw_port");
        apb_xfer("ro_read_hw", 1'b0, 8'd2, 32'h0, 4'hF, 1'b0, 32'h00000077, 1'b0, 8'd0, 32'h0);

        // penable without a setup cycle must not start a transfer.
        max_rdy = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'h0000CAFE;
        repeat (4) begin
            @(negedge pclk);
            if (pready) max_rdy = 1;
            @(posedge pclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        check("no_setup_pready", 32'(max_rdy), 32'd0);
        check("no_setup_reg7", reg_q[7*DW +: DW], 32'h0);

        // psel dropped during wait states aborts the write.
        max_rdy = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'h00000099;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            if (pready) max_rdy = 1;
        end
        check("abort_pready", 32'(max_rdy), 32'd0);
        check_regs("abort");

        // Asynchronous reset while waiting.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd8; pwdata = 32'h0000FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        check("rstmid_pready", {31'b0, pready}, 32'd0);
        check("rstmid_pslverr", {31'b0, pslverr}, 32'd0);
        check("rstmid_prdata", prdata, 32'h0);
        check_regs("rstmid");
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        apb_xfer("post_rst_rd8", 1'b0, 8'd8, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 8'd0, 32'h0);
        apb_xfer("post_rst_wr4", 1'b1, 8'd4, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, 8'd0, 32'h0);
        apb_xfer("post_rst_rd4", 1'b0, 8'd4, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, 1'b0, 8'd0, 32'h0);

`ifdef APB_REGFILE_PSTRB_EN
        apb_xfer("strb_0101", 1'b1, 8'd9, 32'hFFFFFFFF, 4'b0101, 1'b0, 32'h0, 1'b0, 8'd0, 32'h0);
        check("strb_0101_reg9", reg_q[9*DW +: DW], 32'h00FF00FF);
        apb_xfer("strb_none", 1'b1, 8'd9, 32'h12345678, 4'b0000, 1'b0, 32'h0, 1'b0, 8'd0, 32'h0);
        check("strb_none_reg9", reg_q[9*DW +: DW], 32'h00FF00FF);
        apb_xfer("strb_rd9", 1'b0, 8'd9, 32'h0, 4'b0000, 1'b0, 32'h00FF00FF, 1'b0, 8'd0, 32'h0);
`endif
        check_regs("final_main");

        // Zero-wait instance: back-to-back writes then reads, no idle cycles.
        @(posedge pclk); #1;
        psel_z = 1'b1; penable_z = 1'b0; pwrite_z = 1'b1; paddr_z = 2'd0; pwdata_z = 32'h11111111;
        @(negedge pclk);
        check("z_setup0_pready", {31'b0, pready_z}, 32'd0);
        @(posedge pclk); #1;
        penable_z = 1'b1;
        @(negedge pclk);
        check("z_wr0_pready", {31'b0, pready_z}, 32'd1);
        check("z_wr0_pslverr", {31'b0, pslverr_z}, 32'd0);
        @(posedge pclk); #1;
        penable_z = 1'b0; paddr_z = 2'd1; pwdata_z = 32'h22222222;
        @(negedge pclk);
        check("z_setup1_pready", {31'b0, pready_z}, 32'd0);
        check("z_reg0", reg_q_z[0 +: DW], 32'h11111111);
        @(posedge pclk); #1;
        penable_z = 1'b1;
        @(negedge pclk);
        check("z_wr1_pready", {31'b0, pready_z}, 32'd1);
        @(posedge pclk); #1;
        penable_z = 1'b0; pwrite_z = 1'b0; paddr_z = 2'd0;
        @(negedge pclk);
        check("z_reg1", reg_q_z[DW +: DW], 32'h22222222);
        @(posedge pclk); #1;
        penable_z = 1'b1;
        @(negedge pclk);
        check("z_rd0_pready", {31'b0, pready_z}, 32'd1);
        check("z_rd0_prdata", prdata_z, 32'h11111111);
        @(posedge pclk); #1;
        penable_z = 1'b0; paddr_z = 2'd1;
        @(posedge pclk); #1;
        penable_z = 1'b1;
        @(negedge pclk);
        check("z_rd1_pready", {31'b0, pready_z}, 32'd1);
        check("z_rd1_prdata", prdata_z, 32'h22222222);
        check("z_rd1_pslverr", {31'b0, pslverr_z}, 32'd0);
        @(posedge pclk); #1;
        psel_z = 1'b0; penable_z = 1'b0;
        @(negedge pclk);
        check("z_idle_pready", {31'b0, pready_z}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
